// File: rtl/mult_result_checker.sv
// Checks a stream of redundant-digit products against expected two's-complement values.
// The run is sized by num_tests; the 3-stage pipeline feeds saturating test/error counters.
module mult_result_checker #(
    parameter int unsigned NDIG       = 63,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    pll_clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     num_tests,
    input  logic                    valid_in,
    input  logic [ADDR_WIDTH-1:0]   addr_in,
    input  logic [2*NDIG-1:0]       prod_in,
    input  logic [NDIG:0]           exp_in,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    test_count,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic                    first_err_valid,
    output logic [ADDR_WIDTH-1:0]   first_err_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH:0]     num_lat;
    logic [ADDR_WIDTH:0]     acc_cnt;
    logic [ADDR_WIDTH:0]     acc_next;
    logic [1:0]              drain_cnt;

    logic                    accept;
    logic                    start_ok;
    logic [NDIG-1:0]         pos_bits;
    logic [NDIG-1:0]         neg_bits;

    logic                    s1_valid;
    logic [NDIG-1:0]         s1_pos;
    logic [NDIG-1:0]         s1_neg;
    logic [NDIG:0]           s1_exp;
    logic [ADDR_WIDTH-1:0]   s1_addr;

    logic                    s2_valid;
    logic                    s2_match;
    logic [ADDR_WIDTH-1:0]   s2_addr;
    logic [NDIG:0]           diff;

    assign accept   = valid_in && (state == RUN);
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign acc_next = acc_cnt + (ADDR_WIDTH+1)'(1);
    assign diff     = {1'b0, s1_pos} - {1'b0, s1_neg};

    // Even bits carry +2^k, odd bits carry -2^k.
    always_comb begin
        pos_bits = '0;
        neg_bits = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            pos_bits[k] = prod_in[2*k];
            neg_bits[k] = prod_in[2*k+1];
        end
    end

    always_ff @(posedge pll_clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
        end
        s1_pos   <= pos_bits;
        s1_neg   <= neg_bits;
        s1_exp   <= exp_in;
        s1_addr  <= addr_in;
        s2_match <= (diff == s1_exp);
        s2_addr  <= s1_addr;
    end

    always_ff @(posedge pll_clock) begin
        if (reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            num_lat         <= '0;
            acc_cnt         <= '0;
            drain_cnt       <= '0;
            test_count      <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_lat   <= num_tests;
                        acc_cnt   <= '0;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= (num_tests == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        acc_cnt <= acc_next;
                        if (acc_next == num_lat) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new run's clear takes priority over the result stage.
            if (start_ok) begin
                test_count      <= '0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
            end else if (s2_valid) begin
                if (test_count != '1)
                    test_count <= test_count + CNT_WIDTH'(1);
                if (!s2_match) begin
                    if (err_count != '1)
                        err_count <= err_count + CNT_WIDTH'(1);
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_addr  <= s2_addr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_result_checker.sv
// Directed bench for mult_result_checker: a default instance plus a 2-bit-counter instance
// sharing the same stimulus to exercise saturation.
module tb_mult_result_checker;

    localparam int NDIG = 63;
    localparam int AW   = 9;

    localparam logic [2*NDIG-1:0] P5      = 126'h11;
    localparam logic [2*NDIG-1:0] P_ONE   = 126'h6;
    localparam logic [2*NDIG-1:0] P_MAX   = {63{2'b01}};
    localparam logic [2*NDIG-1:0] P_NEG62 = 126'h1 << 125;

    logic              pll_clock = 1'b0;
    logic              reset, start, valid_in;
    logic [AW:0]       num_tests;
    logic [AW-1:0]     addr_in;
    logic [2*NDIG-1:0] prod_in;
    logic [NDIG:0]     exp_in;

    logic              busy, done, first_err_valid;
    logic [15:0]       test_count, err_count;
    logic [AW-1:0]     first_err_addr;

    logic              s_busy, s_done, s_first_err_valid;
    logic [1:0]        s_test_count, s_err_count;
    logic [AW-1:0]     s_first_err_addr;

    logic [2*NDIG-1:0] vprod [16];
    logic [NDIG:0]     vexp  [16];
    logic [AW-1:0]     vaddr [16];

    int checks = 0;
    int errors = 0;

    always #5 pll_clock = ~pll_clock;

    mult_result_checker #(.NDIG(63), .ADDR_WIDTH(9), .CNT_WIDTH(16)) dut (
        .pll_clock(pll_clock), .reset(reset), .start(start), .num_tests(num_tests),
        .valid_in(valid_in), .addr_in(addr_in), .prod_in(prod_in), .exp_in(exp_in),
        .busy(busy), .done(done), .test_count(test_count), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr)
    );

    mult_result_checker #(.NDIG(63), .ADDR_WIDTH(9), .CNT_WIDTH(2)) dut_s (
        .pll_clock(pll_clock), .reset(reset), .start(start), .num_tests(num_tests),
        .valid_in(valid_in), .addr_in(addr_in), .prod_in(prod_in), .exp_in(exp_in),
        .busy(s_busy), .done(s_done), .test_count(s_test_count), .err_count(s_err_count),
        .first_err_valid(s_first_err_valid), .first_err_addr(s_first_err_addr)
    );

    task automatic tick;
        @(negedge pll_clock);
    endtask

    task automatic start_run(input logic [AW:0] n);
        start     = 1'b1;
        num_tests = n;
        tick;
        start     = 1'b0;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            addr_in  = vaddr[i];
            prod_in  = vprod[i];
            exp_in   = vexp[i];
            tick;
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            tick;
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; valid_in = 1'b0; num_tests = '0;
        addr_in = '0; prod_in = '0; exp_in = '0;
        repeat (3) tick;
        checks++; if ({busy, done, first_err_valid} !== 3'b000) begin errors++;
            $display("FAIL reset_flags got %b want 000", {busy, done, first_err_valid}); end
        checks++; if (test_count !== 16'd0) begin errors++;
            $display("FAIL reset_test_count got %0d want 0", test_count); end
        checks++; if (err_count !== 16'd0) begin errors++;
            $display("FAIL reset_err_count got %0d want 0", err_count); end
        checks++; if (first_err_addr !== 9'd0) begin errors++;
            $display("FAIL reset_first_err_addr got %0d want 0", first_err_addr); end
        reset = 1'b0;
        tick;
        checks++; if ({busy, done} !== 2'b00) begin errors++;
            $display("FAIL idle_flags got %b want 00", {busy, done}); end
    endtask

    task automatic test_basic;
        start_run(10'd4);
        checks++; if ({busy, done} !== 2'b10) begin errors++;
            $display("FAIL basic_busy got %b want 10", {busy, done}); end
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; addr_in = AW'(i); prod_in = P5; exp_in = 64'd5;
            if (i == 2) begin
                checks++; if (test_count !== 16'd0) begin errors++;
                    $display("FAIL basic_latency_early got %0d want 0", test_count); end
            end
            if (i == 3) begin
                checks++; if (test_count !== 16'd1) begin errors++;
                    $display("FAIL basic_latency_first got %0d want 1", test_count); end
            end
            tick;
        end
        valid_in = 1'b0;
        repeat (2) tick;
        checks++; if ({busy, done} !== 2'b10) begin errors++;
            $display("FAIL basic_drain got %b want 10", {busy, done}); end
        tick;
        checks++; if ({busy, done} !== 2'b01) begin errors++;
            $display("FAIL basic_done got %b want 01", {busy, done}); end
        checks++; if (test_count !== 16'd4 || err_count !== 16'd0 || first_err_valid !== 1'b0) begin errors++;
            $display("FAIL basic_counts got %0d/%0d/%0b want 4/0/0", test_count, err_count, first_err_valid); end
    endtask

    task automatic test_negative;
        bit ok;
        vprod[0] = P_ONE;   vexp[0] = 64'd1;                 vaddr[0] = 9'd5;
        vprod[1] = P_ONE;   vexp[1] = '1;                    vaddr[1] = 9'd6;
        vprod[2] = P_NEG62; vexp[2] = 64'hC000_0000_0000_0000; vaddr[2] = 9'd7;
        vprod[3] = P_MAX;   vexp[3] = 64'h7FFF_FFFF_FFFF_FFFF; vaddr[3] = 9'd8;
        start_run(10'd4);
        send_beats(4);
        wait_done(8, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL negative_done got 0 want 1"); end
        checks++; if (test_count !== 16'd4 || err_count !== 16'd1) begin errors++;
            $display("FAIL negative_counts got %0d/%0d want 4/1", test_count, err_count); end
        checks++; if (first_err_valid !== 1'b1 || first_err_addr !== 9'd6) begin errors++;
            $display("FAIL negative_first_err got %0b/%0d want 1/6", first_err_valid, first_err_addr); end
    endtask

    task automatic test_errors;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            vprod[i] = P5; vexp[i] = 64'd0; vaddr[i] = AW'(7 + i);
        end
        start_run(10'd3);
        send_beats(3);
        wait_done(8, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL errors_done got 0 want 1"); end
        checks++; if (test_count !== 16'd3 || err_count !== 16'd3) begin errors++;
            $display("FAIL errors_counts got %0d/%0d want 3/3", test_count, err_count); end
        checks++; if (first_err_valid !== 1'b1 || first_err_addr !== 9'd7) begin errors++;
            $display("FAIL errors_first_err got %0b/%0d want 1/7", first_err_valid, first_err_addr); end
    endtask

    task automatic test_ignored;
        valid_in = 1'b1; prod_in = P5; exp_in = 64'd0; addr_in = 9'd40;
        repeat (3) tick;
        valid_in = 1'b0;
        repeat (4) tick;
        checks++; if (test_count !== 16'd3 || err_count !== 16'd3 || done !== 1'b1 || first_err_addr !== 9'd7) begin errors++;
            $display("FAIL done_hold got %0d/%0d/%0b/%0d want 3/3/1/7", test_count, err_count, done, first_err_addr); end
        reset = 1'b1; tick; reset = 1'b0;
        valid_in = 1'b1;
        repeat (3) tick;
        valid_in = 1'b0;
        repeat (4) tick;
        checks++; if (test_count !== 16'd0 || err_count !== 16'd0 || {busy, done} !== 2'b00) begin errors++;
            $display("FAIL idle_ignore got %0d/%0d/%b want 0/0/00", test_count, err_count, {busy, done}); end
        start_run(10'd3);
        valid_in = 1'b1; prod_in = P5; exp_in = 64'd5; addr_in = 9'd20;
        tick;
        addr_in = 9'd21; start = 1'b1; num_tests = 10'd1;
        tick;
        start = 1'b0; addr_in = 9'd22;
        tick;
        addr_in = 9'd23; exp_in = 64'd0;
        tick;
        valid_in = 1'b0;
        tick;
        checks++; if ({busy, done} !== 2'b10) begin errors++;
            $display("FAIL restart_drain got %b want 10", {busy, done}); end
        tick;
        checks++; if ({busy, done} !== 2'b01) begin errors++;
            $display("FAIL restart_done got %b want 01", {busy, done}); end
        checks++; if (test_count !== 16'd3 || err_count !== 16'd0) begin errors++;
            $display("FAIL restart_counts got %0d/%0d want 3/0", test_count, err_count); end
    endtask

    task automatic test_zero;
        start_run(10'd0);
        checks++; if ({busy, done} !== 2'b10 || test_count !== 16'd0) begin errors++;
            $display("FAIL zero_start got %b/%0d want 10/0", {busy, done}, test_count); end
        valid_in = 1'b1; prod_in = P5; exp_in = 64'd0;
        repeat (2) tick;
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL zero_early_done got %0b want 0", done); end
        valid_in = 1'b0;
        tick;
        checks++; if (done !== 1'b1 || test_count !== 16'd0 || err_count !== 16'd0 || first_err_valid !== 1'b0) begin errors++;
            $display("FAIL zero_done got %0b/%0d/%0d/%0b want 1/0/0/0", done, test_count, err_count, first_err_valid); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            vaddr[i] = AW'(100 + i);
            vprod[i] = (i % 2 == 0) ? P5 : P_ONE;
            vexp[i]  = (i % 2 == 0) ? 64'd5 : 64'd1;
        end
        vexp[3] = 64'd0;
        vexp[6] = 64'hFFFF_FFFF_FFFF_FFFB;
        start_run(10'd8);
        send_beats(8);
        wait_done(8, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL b2b_done got 0 want 1"); end
        checks++; if (test_count !== 16'd8 || err_count !== 16'd2 || first_err_addr !== 9'd103) begin errors++;
            $display("FAIL b2b_counts got %0d/%0d/%0d want 8/2/103", test_count, err_count, first_err_addr); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        vprod[0] = P5; vexp[0] = 64'd0; vaddr[0] = 9'd30;
        vprod[1] = P5; vexp[1] = 64'd0; vaddr[1] = 9'd31;
        start_run(10'd5);
        send_beats(2);
        tick;
        checks++; if (test_count !== 16'd1 || err_count !== 16'd1 || busy !== 1'b1) begin errors++;
            $display("FAIL mid_before_reset got %0d/%0d/%0b want 1/1/1", test_count, err_count, busy); end
        reset = 1'b1;
        tick;
        checks++; if ({busy, done, first_err_valid} !== 3'b000 || test_count !== 16'd0 || err_count !== 16'd0 || first_err_addr !== 9'd0) begin errors++;
            $display("FAIL mid_reset got %b/%0d/%0d/%0d want 000/0/0/0", {busy, done, first_err_valid}, test_count, err_count, first_err_addr); end
        reset = 1'b0;
        tick;
        checks++; if (test_count !== 16'd0 || err_count !== 16'd0) begin errors++;
            $display("FAIL mid_inflight got %0d/%0d want 0/0", test_count, err_count); end
        vexp[0] = 64'd5; vexp[1] = 64'd5;
        start_run(10'd2);
        send_beats(2);
        wait_done(8, ok);
        checks++; if (!ok || test_count !== 16'd2 || err_count !== 16'd0 || first_err_valid !== 1'b0) begin errors++;
            $display("FAIL mid_fresh_run got %0b/%0d/%0d/%0b want 1/2/0/0", ok, test_count, err_count, first_err_valid); end
    endtask

    task automatic test_saturation;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            vprod[i] = P5; vexp[i] = 64'd4; vaddr[i] = AW'(50 + i);
        end
        start_run(10'd5);
        send_beats(5);
        wait_done(8, ok);
        checks++; if (!ok || err_count !== 16'd5 || test_count !== 16'd5) begin errors++;
            $display("FAIL sat_wide got %0b/%0d/%0d want 1/5/5", ok, test_count, err_count); end
        checks++; if (s_err_count !== 2'd3 || s_test_count !== 2'd3) begin errors++;
            $display("FAIL sat_narrow got %0d/%0d want 3/3", s_test_count, s_err_count); end
        checks++; if ({s_busy, s_done, s_first_err_valid} !== 3'b011 || s_first_err_addr !== 9'd50) begin errors++;
            $display("FAIL sat_narrow_flags got %b/%0d want 011/50", {s_busy, s_done, s_first_err_valid}, s_first_err_addr); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_negative;
        test_errors;
        test_ignored;
        test_zero;
        test_back_to_back;
        test_reset_mid;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_result_checker.md
MULT_RESULT_CHECKER -- requirements
Module: mult_result_checker

Interface
REQ-001 SHALL have parameter NDIG, default 63: product digit count; each digit is 2 bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: result address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the test and error counters.
REQ-004 pll_clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a check run.
REQ-007 num_tests  in  ADDR_WIDTH+1  number of products to check; sampled when start is accepted.
REQ-008 valid_in  in  1  prod_in, exp_in and addr_in are valid this cycle.
REQ-009 addr_in  in  ADDR_WIDTH  result address of the current product.
REQ-010 prod_in  in  2*NDIG  redundant product; digit k: bit 2k = +2^k, bit 2k+1 = -2^k.
REQ-011 exp_in  in  NDIG+1  expected value, two's complement.
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done  out  1  high in DONE.
REQ-014 test_count  out  CNT_WIDTH  products checked.
REQ-015 err_count  out  CNT_WIDTH  mismatching products.
REQ-016 first_err_valid  out  1  first_err_addr holds a captured address.
REQ-017 first_err_addr  out  ADDR_WIDTH  address of the first mismatch in the run.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE or DONE with start=1: SHALL clear test_count, err_count, first_err_valid, first_err_addr and the internal accept counter, latch num_tests, and go to RUN; go to DRAIN instead if num_tests=0.
REQ-020 start SHALL be ignored in RUN and DRAIN.
REQ-021 valid_in SHALL be accepted only in RUN; it is ignored in every other state.
REQ-022 Each accepted beat SHALL increment the accept counter; on the beat that makes it equal the latched num_tests, the state SHALL go to DRAIN.
REQ-023 Stage 1 (registered): pos = even bits of prod_in, neg = odd bits, plus addr and valid.
REQ-024 Stage 2 (registered): diff = zero-extend(pos) - zero-extend(neg), computed in NDIG+1 bits.
REQ-025 Stage 2: match = (diff == exp_in delayed one cycle).
REQ-026 Stage 3: a valid stage-2 beat SHALL increment test_count.
REQ-027 Stage 3: if !match, SHALL also increment err_count.
REQ-028 Stage 3: if !match and !first_err_valid, SHALL capture the beat's address and set first_err_valid.
REQ-029 Counters are updated 3 cycles after the accepted valid_in cycle.
REQ-030 Counters SHALL saturate at all-ones and never wrap.
REQ-031 DRAIN SHALL last exactly 3 cycles, enough for every accepted beat to reach the counters, then go to DONE.
REQ-032 DONE SHALL hold all outputs stable until start.
REQ-033 Back-to-back valid_in SHALL be accepted every cycle with no bubbles; the block has no backpressure.
REQ-034 Beats in flight when the state leaves RUN SHALL still be counted.

Reset
REQ-035 With reset=1 at a clock edge:
- state = IDLE
- busy = 0, done = 0
- test_count = 0, err_count = 0
- first_err_valid = 0, first_err_addr = 0
- accept counter = 0, all pipeline valids = 0
REQ-036 Reset mid-run SHALL abandon the run: in-flight beats are discarded and no counter changes on the following cycle.

Verification
REQ-037 Run with NDIG=63: start with num_tests=4; 4 consecutive beats, prod_in encoding +5 (bits 0 and 4 set), exp_in=5 -> busy 1 cycle after start; done 4 cycles after the last beat; test_count=4, err_count=0, first_err_valid=0.
REQ-038 Negative value: prod_in with bit 1 set (-1) and bit 2 set (+2), exp_in=1 -> match. Same prod_in with exp_in=all-ones (-1) -> err_count=1, first_err_valid=1.
REQ-039 num_tests=3: beats at addr 7, 8, 9 all mismatching -> err_count=3, first_err_addr=7.
REQ-040 Ignored inputs: valid_in pulses in IDLE and DONE -> no counter change. A second start mid-RUN -> ignored; run finishes with the original num_tests.
REQ-041 num_tests=0 -> no beats counted; done 4 cycles after start; counters 0.
REQ-042 Reset mid-run after 2 of 5 beats -> next cycle IDLE with all counters 0. A fresh start then runs normally. With CNT_WIDTH=2 and 5 mismatches -> err_count=3 (saturated).
